// File: rtl/block_stream_gen_pkg.sv
// Shared definitions for the BEGIN/END character-stream transmitter:
// command encoding, FSM states, ASCII constants and word lengths.
package block_stream_pkg;

  typedef enum logic [1:0] {
    CMD_BEGIN  = 2'd0,
    CMD_END    = 2'd1,
    CMD_FILLER = 2'd2,
    CMD_SPACE  = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SEP  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_B     = 8'h62;
  localparam logic [7:0] ASCII_E     = 8'h65;
  localparam logic [7:0] ASCII_G     = 8'h67;
  localparam logic [7:0] ASCII_I     = 8'h69;
  localparam logic [7:0] ASCII_N     = 8'h6E;
  localparam logic [7:0] ASCII_D     = 8'h64;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] CASE_BIT    = 8'h20;

  localparam logic [3:0] LEN_BEGIN = 4'd5;
  localparam logic [3:0] LEN_END   = 4'd3;

  // Letters emitted for a word; a FILLER length of 0 encodes 8.
  function automatic logic [3:0] word_len(input cmd_t c, input logic [2:0] len);
    case (c)
      CMD_BEGIN:  word_len = LEN_BEGIN;
      CMD_END:    word_len = LEN_END;
      CMD_FILLER: word_len = (len == 3'd0) ? 4'd8 : {1'b0, len};
      default:    word_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/block_stream_gen_if.sv
// Command handshake bus between a token sender and block_stream_gen.
interface block_stream_gen_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [2:0] cmd_len;
  logic [7:0] case_mask;

  modport master (output cmd_valid, cmd, cmd_len, case_mask, input cmd_ready);
  modport slave  (input cmd_valid, cmd, cmd_len, case_mask, output cmd_ready);
endinterface

// File: rtl/block_stream_gen_char_rom.sv
// Combinational character lookup: (command, letter index, uppercase) -> ASCII.
module block_char_rom
  import block_stream_pkg::*;
(
  input  cmd_t       i_cmd,
  input  logic [2:0] i_index,
  input  logic       i_upper,
  output logic [7:0] o_char
);

  logic [7:0] w_lower;

  always_comb begin
    w_lower = ASCII_SPACE;
    case (i_cmd)
      CMD_BEGIN: begin
        case (i_index)
          3'd0:    w_lower = ASCII_B;
          3'd1:    w_lower = ASCII_E;
          3'd2:    w_lower = ASCII_G;
          3'd3:    w_lower = ASCII_I;
          3'd4:    w_lower = ASCII_N;
          default: w_lower = ASCII_SPACE;
        endcase
      end
      CMD_END: begin
        case (i_index)
          3'd0:    w_lower = ASCII_E;
          3'd1:    w_lower = ASCII_N;
          3'd2:    w_lower = ASCII_D;
          default: w_lower = ASCII_SPACE;
        endcase
      end
      CMD_FILLER: w_lower = ASCII_X;
      default:    w_lower = ASCII_SPACE;
    endcase
  end

  assign o_char = (i_upper && (w_lower != ASCII_SPACE)) ? (w_lower & ~CASE_BIT) : w_lower;

endmodule

// File: rtl/block_stream_gen.sv
// Token-to-character transmitter feeding the BEGIN/END block checker.
// Optional BLOCK_GEN_DEPTH_GUARD_EN: illegal BEGIN/END are swallowed and flagged on drop.
module block_stream_gen
  import block_stream_pkg::*;
#(
  parameter int unsigned DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  block_stream_gen_if.slave  cmd_if,
  output logic [7:0]         out,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err,
  output logic               drop
);

  state_t             r_state, w_next;
  cmd_t               r_cmd;
  logic [2:0]         r_len;
  logic [7:0]         r_mask;
  logic [2:0]         r_index;
  logic [7:0]         r_out;
  logic [DEPTH_W-1:0] r_depth;

  cmd_t       w_cmd;
  logic       w_ready, w_accept, w_last, w_full, w_empty, w_bad, w_guard;
  logic [7:0] w_rom, w_char;

  assign w_cmd    = cmd_t'(cmd_if.cmd);
  assign w_accept = cmd_if.cmd_valid & w_ready;
  assign w_last   = ({1'b0, r_index} == (word_len(r_cmd, r_len) - 4'd1));
  assign w_full   = (r_depth == '1);
  assign w_empty  = (r_depth == '0);
  assign w_bad    = w_accept && (((w_cmd == CMD_BEGIN) && w_full) ||
                                 ((w_cmd == CMD_END) && w_empty));
`ifdef BLOCK_GEN_DEPTH_GUARD_EN
  assign w_guard = w_bad;
`else
  assign w_guard = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_SEP: begin
        if (!w_accept || w_guard)     w_next = ST_IDLE;
        else if (w_cmd == CMD_SPACE)  w_next = ST_SEP;
        else                          w_next = ST_EMIT;
      end
      ST_EMIT: if (w_last) w_next = ST_SEP;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (r_state != ST_EMIT);
    w_char  = (r_state == ST_EMIT) ? w_rom : ASCII_SPACE;
  end

  block_char_rom u_rom (
    .i_cmd   (r_cmd),
    .i_index (r_index),
    .i_upper (r_mask[r_index]),
    .o_char  (w_rom)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd   <= CMD_SPACE;
      r_len   <= '0;
      r_mask  <= '0;
      r_index <= '0;
      r_out   <= ASCII_SPACE;
    end else begin
      r_out <= w_char;
      if (w_accept) begin
        r_cmd   <= w_cmd;
        r_len   <= cmd_if.cmd_len;
        r_mask  <= cmd_if.case_mask;
        r_index <= '0;
      end else if (r_state == ST_EMIT) begin
        r_index <= r_index + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth <= '0;
    end else if (w_accept) begin
      if ((w_cmd == CMD_BEGIN) && !w_full)  r_depth <= r_depth + DEPTH_W'(1);
      if ((w_cmd == CMD_END) && !w_empty)   r_depth <= r_depth - DEPTH_W'(1);
    end
  end

`ifdef BLOCK_GEN_DEPTH_GUARD_EN
  logic r_drop;
  always_ff @(posedge clk) begin
    if (reset) r_drop <= 1'b0;
    else       r_drop <= w_bad;
  end
  assign drop = r_drop;
  assign err  = 1'b0;
`else
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset)      r_err <= 1'b0;
    else if (w_bad) r_err <= 1'b1;
  end
  assign drop = 1'b0;
  assign err  = r_err;
`endif

  assign cmd_if.cmd_ready = w_ready;
  assign out              = r_out;
  assign depth            = r_depth;
  assign balanced         = w_empty && !err;

endmodule

// File: doc/block_stream_gen.md
# block_stream_gen

Character-stream transmitter for the BEGIN/END block checker. Accepts token commands over a valid/ready handshake and emits one ASCII character per clock on `out`, formatted as space-separated words (`begin`, `end`, or filler). It drives the checker's `in` port directly, so it produces a legal character every cycle, idling on spaces. It also tracks nesting depth so the bench knows the expected checker `result`.

## Interface
- `DEPTH_W`, 4: width of nesting-depth counter.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  command accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd`  input  2  token kind: 0 BEGIN, 1 END, 2 FILLER, 3 SPACE.
- `cmd_len`  input  3  FILLER length in characters; 0 means 8.
- `case_mask`  input  8  bit i=1 makes character i uppercase (bit 0 = first letter).
- `out`  output  8  ASCII character, registered, valid every cycle.
- `depth`  output  DEPTH_W  current open-block count.
- `balanced`  output  1  `depth==0` and no sticky error.
- `err`  output  1  sticky: END at depth 0, or BEGIN at max depth.
- `drop`  output  1  one-cycle pulse when a command is discarded (macro build only).

## Operation
- FSM states:
  - IDLE: `out`=8'h20, `cmd_ready`=1.
  - EMIT: letters, `cmd_ready`=0.
  - SEP: one trailing space, `cmd_ready`=1.
- Accept in IDLE or SEP:
  - BEGIN/END/FILLER go to EMIT with index 0.
  - SPACE goes to SEP, emitting one extra space.
- EMIT outputs letter `index` of the word, then increments `index`. After the last letter it goes to SEP.
  - Word lengths: BEGIN 5 (`begin`), END 3 (`end`), FILLER `cmd_len` characters of `x`.
- Letter case: letter i is uppercase when `case_mask[i]` is 1. Uppercase is lowercase with bit 5 cleared (for example `b` 8'h62 becomes `B` 8'h42).
- SEP with no command accepted goes to IDLE.
- `cmd`, `cmd_len` and `case_mask` are latched at acceptance and held for the whole word.
- Depth is updated at acceptance:
  - BEGIN: +1. At 2^DEPTH_W−1 the depth saturates and `err` is set.
  - END: −1. At 0 the depth stays 0 and `err` is set.
- `err` clears only on reset.

## Timing
- Reset values: state IDLE, `out`=8'h20, `cmd_ready`=1, `depth`=0, `err`=0, `balanced`=1, `drop`=0.
- Latency: command accepted at edge T puts its first letter on `out` after edge T+1.
- A BEGIN occupies 6 consecutive cycles (5 letters + space). Back-to-back commands are accepted during SEP with no idle gap.
- A FILLER with `cmd_len`=0 emits 8 letters. `case_mask` covers all 8 positions.
- Reset asserted mid-word aborts the word. `out` is 8'h20 on the next cycle. The partial word is never resumed.
- `cmd_valid` is ignored while `cmd_ready`=0. The sender must hold it.

## Configuration
- `BLOCK_GEN_DEPTH_GUARD_EN` defined:
  - An END at depth 0 or a BEGIN at max depth is accepted (handshake completes) but emits nothing.
  - The FSM stays in or returns to IDLE, `drop` pulses for one cycle, `err` stays 0, and `depth` is unchanged.
- Undefined:
  - The word is emitted and `err` is set as described in Operation.
  - `drop` is tied 0.

## Structure
- Package `block_stream_pkg` holds:
  - the cmd encoding constants;
  - the FSM state enum;
  - ASCII constants: space 8'h20, the letters of `begin`/`end`, and `x`;
  - word lengths 5/3.
- Sub-module `block_char_rom`: combinational `(cmd, index, upper) -> char` lookup. The top holds the FSM, index counter, depth/err logic and output register.

## Test plan
- Reset, no commands → `out`=8'h20 every cycle, `depth`=0, `balanced`=1.
- BEGIN with `case_mask`=8'h05 then END with 8'h00 → `out` sequence `B e G i n _ e n d _`, `depth` goes 1 then 0, `balanced`=1, no idle cycle between words.
- FILLER with `cmd_len`=0 and `case_mask`=8'h80 → `x x x x x x x X _`, depth unchanged.
- END at depth 0:
  - without the macro → `e n d _`, `err`=1, `balanced`=0;
  - with the macro → only spaces, `drop` pulses once, `err`=0.
- 16 BEGINs with DEPTH_W=4 → depth saturates at 15, `err`=1 (macro undefined).
- Reset asserted during letter 3 of BEGIN → next `out`=8'h20, `depth`=0, `cmd_ready`=1.
